// File: rtl/stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stream_pkg
//  Description : Shared types for the 32-bit valid/ready stream family
//                (distributor and arbiter).
//                STREAM_DATA_W - stream word width
//                stream_data_t - stream word type
//                stream_dest_t - output selector (DEST_A / DEST_B)
//  Revision    : 1.0 - initial release
// ============================================================================
package stream_pkg;

    localparam int STREAM_DATA_W = 32;

    typedef logic [STREAM_DATA_W-1:0] stream_data_t;

    typedef enum logic {
        DEST_A = 1'b0,
        DEST_B = 1'b1
    } stream_dest_t;

endpackage
`default_nettype wire

// File: rtl/dist_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : dist_fifo
//  Description : Synchronous per-output FIFO for stream_distributor.
//                DEPTH must be a power of two, minimum 2.
//  Ports       : i_clk, i_rst (async, active-high)
//                i_push / i_push_data - write request and word
//                i_pop                - read request (ignored when empty)
//                o_full / o_empty     - occupancy flags
//                o_head               - oldest word (0 when empty)
//  Revision    : 1.0 - initial release
// ============================================================================
module dist_fifo
    import stream_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [STREAM_DATA_W-1:0] i_push_data,
    input  logic                     i_pop,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [STREAM_DATA_W-1:0] o_head
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    stream_data_t         r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;

    logic                 w_push;
    logic                 w_pop;

    assign o_full  = (r_count == c_CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);

    // A full FIFO refuses a push even when it pops in the same cycle, so the
    // full flag alone gates writes; the caller keeps the word until next cycle.
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Head is forced to zero while empty so the output reads 0 out of reset.
    assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

    // Storage carries no reset; only pointers and count define its contents.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/stream_distributor.sv
`default_nettype none
// ============================================================================
//  Module      : stream_distributor
//  Description : One-in, two-out valid/ready stream distributor. Each word
//                accepted on X passes through a hold register and is pushed
//                into the FIFO of output A or B.
//                Build option DISTRIBUTOR_RR_EN: destination alternates
//                A,B,A,... per accepted word; otherwise it is
//                i_x_data[ROUTE_BIT] (0 -> A, 1 -> B).
//  Ports       : i_clk, i_rst (async, active-high)
//                i_x_data / i_x_valid / o_x_ready - inbound stream
//                o_a_data / o_a_valid / i_a_ready - output A
//                o_b_data / o_b_valid / i_b_ready - output B
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_distributor
    import stream_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter int ROUTE_BIT = 31
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [STREAM_DATA_W-1:0] i_x_data,
    input  logic                     i_x_valid,
    output logic                     o_x_ready,
    output logic [STREAM_DATA_W-1:0] o_a_data,
    output logic                     o_a_valid,
    input  logic                     i_a_ready,
    output logic [STREAM_DATA_W-1:0] o_b_data,
    output logic                     o_b_valid,
    input  logic                     i_b_ready
);

    logic         r_hold_valid;
    stream_data_t r_hold_data;
    stream_dest_t r_hold_dest;

    stream_dest_t w_x_dest;
    logic         w_x_fire;
    logic         w_drain;
    logic         w_a_full;
    logic         w_a_empty;
    logic         w_b_full;
    logic         w_b_empty;

    // Draining depends only on registered state (hold + FIFO counts), so
    // o_x_ready has no combinational path from i_x_data.
    assign w_drain   = r_hold_valid &&
                       ((r_hold_dest == DEST_A) ? !w_a_full : !w_b_full);
    assign o_x_ready = !i_rst && (!r_hold_valid || w_drain);
    assign w_x_fire  = i_x_valid && o_x_ready;

`ifdef DISTRIBUTOR_RR_EN
    stream_dest_t r_rr_ptr;

    assign w_x_dest = r_rr_ptr;

    // Pointer only moves on an accepted word, so X stalls do not skip a slot.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rr_ptr <= DEST_A;
        end else if (w_x_fire) begin
            r_rr_ptr <= (r_rr_ptr == DEST_A) ? DEST_B : DEST_A;
        end
    end
`else
    assign w_x_dest = stream_dest_t'(i_x_data[ROUTE_BIT]);
`endif

    // Load wins over drain: a drain and a new word in the same cycle simply
    // replaces the hold contents.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hold_valid <= 1'b0;
            r_hold_data  <= '0;
            r_hold_dest  <= DEST_A;
        end else if (w_x_fire) begin
            r_hold_valid <= 1'b1;
            r_hold_data  <= i_x_data;
            r_hold_dest  <= w_x_dest;
        end else if (w_drain) begin
            r_hold_valid <= 1'b0;
        end
    end

    dist_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo_a (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (w_drain && (r_hold_dest == DEST_A)),
        .i_push_data (r_hold_data),
        .i_pop       (i_a_ready),
        .o_full      (w_a_full),
        .o_empty     (w_a_empty),
        .o_head      (o_a_data)
    );

    dist_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo_b (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (w_drain && (r_hold_dest == DEST_B)),
        .i_push_data (r_hold_data),
        .i_pop       (i_b_ready),
        .o_full      (w_b_full),
        .o_empty     (w_b_empty),
        .o_head      (o_b_data)
    );

    assign o_a_valid = !w_a_empty;
    assign o_b_valid = !w_b_empty;

endmodule
`default_nettype wire

// File: tb/tb_stream_distributor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_distributor
//  Description : Self-checking bench for stream_distributor. Cycle tables
//                for routed split and backpressure, plus hand sequences for
//                streaming, mid-flight reset and (DISTRIBUTOR_RR_EN) the
//                round-robin order.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_distributor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] x_data = '0;
    logic        x_valid = 1'b0;
    logic        a_ready = 1'b0;
    logic        b_ready = 1'b0;
    logic        x_ready;
    logic [31:0] a_data;
    logic        a_valid;
    logic [31:0] b_data;
    logic        b_valid;

    stream_distributor #(
        .DEPTH     (2),
        .ROUTE_BIT (31)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_x_data  (x_data),
        .i_x_valid (x_valid),
        .o_x_ready (x_ready),
        .o_a_data  (a_data),
        .o_a_valid (a_valid),
        .i_a_ready (a_ready),
        .o_b_data  (b_data),
        .o_b_valid (b_valid),
        .i_b_ready (b_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] qa[$];
    logic [31:0] qb[$];
    int          na = 0;
    int          nb = 0;

    typedef struct {
        logic [31:0] xd;
        logic        xv;
        logic        ar;
        logic        br;
        logic        exr;
        logic        eav;
        logic [31:0] ead;
        logic        ebv;
        logic [31:0] ebd;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic [31:0] xd, logic xv, logic ar, logic br,
                                logic exr, logic eav, logic [31:0] ead,
                                logic ebv, logic [31:0] ebd);
        vec_t v;
        v.xd = xd; v.xv = xv; v.ar = ar; v.br = br;
        v.exr = exr; v.eav = eav; v.ead = ead; v.ebv = ebv; v.ebd = ebd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called #1 after a negedge: any output handshake seen here completes
    // at the next rising edge, so it is scored against the expected queue.
    task automatic mon();
        if (a_valid && a_ready) begin
            if (qa.size() == 0) chk("a_unexpected_valid", {31'b0, a_valid}, 32'd0);
            else begin chk("a_data", a_data, qa.pop_front()); na++; end
        end
        if (b_valid && b_ready) begin
            if (qb.size() == 0) chk("b_unexpected_valid", {31'b0, b_valid}, 32'd0);
            else begin chk("b_data", b_data, qb.pop_front()); nb++; end
        end
    endtask

    initial begin
        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_x_ready", {31'b0, x_ready}, 32'd0);
        chk("rst_a_valid", {31'b0, a_valid}, 32'd0);
        chk("rst_b_valid", {31'b0, b_valid}, 32'd0);
        chk("rst_a_data", a_data, 32'd0);
        chk("rst_b_data", b_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_x_ready", {31'b0, x_ready}, 32'd1);

`ifdef DISTRIBUTOR_RR_EN
        // ---------------- round-robin order with an X stall ----------------
        a_ready = 1'b1;
        b_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            x_data  = 32'h8000_0000 | 32'(k);
            x_valid = 1'b1;
            if (k % 2 == 0) qa.push_back(x_data); else qb.push_back(x_data);
            #1;
            chk($sformatf("rr_xr%0d", k), {31'b0, x_ready}, 32'd1);
            mon();
            if (k == 1) begin
                for (int s = 0; s < 2; s++) begin
                    @(negedge clk);
                    x_valid = 1'b0;
                    #1;
                    mon();
                end
            end
        end
        @(negedge clk);
        x_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1; mon();
            @(negedge clk);
        end
        chk("rr_a_count", 32'(na), 32'd3);
        chk("rr_b_count", 32'(nb), 32'd2);
`else
        // ---------------- table: routed split, then backpressure ----------
        //           x_data        xv ar br  xr av a_data        bv b_data
        vt.push_back(mk(32'h0000_0001, 1, 1, 1,  1, 0, 32'h0,         0, 32'h0));
        vt.push_back(mk(32'h8000_0002, 1, 1, 1,  1, 0, 32'h0,         0, 32'h0));
        vt.push_back(mk(32'h0000_0003, 1, 1, 1,  1, 1, 32'h1,         0, 32'h0));
        vt.push_back(mk(32'h0000_0000, 0, 1, 1,  1, 0, 32'h0,         1, 32'h8000_0002));
        vt.push_back(mk(32'h0000_0000, 0, 1, 1,  1, 1, 32'h3,         0, 32'h0));
        vt.push_back(mk(32'h0000_0000, 0, 1, 1,  1, 0, 32'h0,         0, 32'h0));
        // A stalled: two A words fill FIFO A, third sits in hold, B word blocked
        vt.push_back(mk(32'h0000_0010, 1, 0, 1,  1, 0, 32'h0,         0, 32'h0));
        vt.push_back(mk(32'h0000_0011, 1, 0, 1,  1, 0, 32'h0,         0, 32'h0));
        vt.push_back(mk(32'h0000_0012, 1, 0, 1,  1, 1, 32'h10,        0, 32'h0));
        vt.push_back(mk(32'h8000_0020, 1, 0, 1,  0, 1, 32'h10,        0, 32'h0));
        vt.push_back(mk(32'h8000_0020, 1, 0, 1,  0, 1, 32'h10,        0, 32'h0));
        // one-cycle ready pulse on a full FIFO: pop now, push next cycle
        vt.push_back(mk(32'h8000_0020, 1, 1, 1,  0, 1, 32'h10,        0, 32'h0));
        vt.push_back(mk(32'h8000_0020, 1, 0, 1,  1, 1, 32'h11,        0, 32'h0));
        vt.push_back(mk(32'h0000_0000, 0, 0, 1,  1, 1, 32'h11,        0, 32'h0));
        vt.push_back(mk(32'h0000_0000, 0, 1, 1,  1, 1, 32'h11,        1, 32'h8000_0020));
        vt.push_back(mk(32'h0000_0000, 0, 1, 1,  1, 1, 32'h12,        0, 32'h0));
        vt.push_back(mk(32'h0000_0000, 0, 1, 1,  1, 0, 32'h0,         0, 32'h0));

        foreach (vt[i]) begin
            @(negedge clk);
            x_data  = vt[i].xd;
            x_valid = vt[i].xv;
            a_ready = vt[i].ar;
            b_ready = vt[i].br;
            #1;
            chk($sformatf("v%0d_x_ready", i), {31'b0, x_ready}, {31'b0, vt[i].exr});
            chk($sformatf("v%0d_a_valid", i), {31'b0, a_valid}, {31'b0, vt[i].eav});
            if (vt[i].eav) chk($sformatf("v%0d_a_data", i), a_data, vt[i].ead);
            chk($sformatf("v%0d_b_valid", i), {31'b0, b_valid}, {31'b0, vt[i].ebv});
            if (vt[i].ebv) chk($sformatf("v%0d_b_data", i), b_data, vt[i].ebd);
        end

        // ---------------- streaming: 64 words, alternating route -----------
        a_ready = 1'b1;
        b_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            x_data  = 32'(i) | ((i % 2 == 1) ? 32'h8000_0000 : 32'h0);
            x_valid = 1'b1;
            if (i % 2 == 1) qb.push_back(x_data); else qa.push_back(x_data);
            #1;
            chk($sformatf("stream_xr%0d", i), {31'b0, x_ready}, 32'd1);
            mon();
        end
        @(negedge clk);
        x_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1; mon();
            @(negedge clk);
        end
        chk("stream_a_count", 32'(na), 32'd32);
        chk("stream_b_count", 32'(nb), 32'd32);

        // ---------------- reset mid-flight ----------------
        a_ready = 1'b0;
        b_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            case (k)
                0: x_data = 32'h0000_0021;
                1: x_data = 32'h0000_0022;
                2: x_data = 32'h8000_0023;
                3: x_data = 32'h8000_0024;
                default: x_data = 32'h0000_0025;
            endcase
            x_valid = 1'b1;
            #1;
            chk($sformatf("fill_xr%0d", k), {31'b0, x_ready}, 32'd1);
        end
        @(negedge clk);
        x_valid = 1'b0;
        #1;
        chk("fill_x_ready_blocked", {31'b0, x_ready}, 32'd0);
        chk("fill_a_head", a_data, 32'h0000_0021);
        chk("fill_b_head", b_data, 32'h8000_0023);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_a_valid", {31'b0, a_valid}, 32'd0);
        chk("midrst_b_valid", {31'b0, b_valid}, 32'd0);
        chk("midrst_x_ready", {31'b0, x_ready}, 32'd0);
        chk("midrst_a_data", a_data, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst     = 1'b0;
        a_ready = 1'b1;
        b_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("postrst_xr%0d", k), {31'b0, x_ready}, 32'd1);
            chk($sformatf("postrst_av%0d", k), {31'b0, a_valid}, 32'd0);
            chk($sformatf("postrst_bv%0d", k), {31'b0, b_valid}, 32'd0);
            @(negedge clk);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stream_distributor.md
# stream_distributor

Single-input, dual-output valid/ready stream distributor: the counterpart to the two-into-one arbiter on the same 32-bit stream interface. Each word accepted on the X port is steered to output A or output B, either by a routing bit in the word or by strict alternation (build option). Each output has its own FIFO, so backpressure on one output does not stall traffic to the other until that output's FIFO and the hold register back up.

## Interface
- DEPTH, 2, entries per output FIFO; power of two, minimum 2
- ROUTE_BIT, 31, index of the data bit selecting the destination (0 → A, 1 → B); ignored when round-robin is compiled in
- i_clk  input  1  clock
- i_rst  input  1  reset, asynchronous, active-high
- i_x_data  input  32  inbound word
- i_x_valid  input  1  inbound word valid
- o_x_ready  output  1  distributor can accept
- o_a_data  output  32  output A word
- o_a_valid  output  1  output A valid
- i_a_ready  input  1  A sink ready
- o_b_data  output  32  output B word
- o_b_valid  output  1  output B valid
- i_b_ready  input  1  B sink ready

## Operation
- Transfers occur on any port when valid and ready are both high at a rising edge.
- Data is passed unmodified; the routing bit is not stripped.
- The source must hold valid and data stable until the transfer; the block guarantees the same on A and B.
- **Stage 1, hold register (hold_valid, hold_data, hold_dest)**
  - Loaded on an X transfer.
  - hold_dest is sampled from i_x_data[ROUTE_BIT], or from the round-robin pointer.
  - The hold register drains when its destination FIFO is not full.
  - o_x_ready = !i_rst && (!hold_valid || drain): a fully registered decision, with no path from i_x_data.
- **Stage 2, per-output FIFO (dist_fifo)**
  - Push on drain to the selected FIFO; pop on an A/B transfer.
  - o_*_valid = FIFO not empty; o_*_data = FIFO head.
- **FIFO full/empty**
  - A full FIFO refuses a push even if it pops in the same cycle; the hold register stays loaded.
  - Simultaneous push and pop on a non-full FIFO leaves the count unchanged.
  - An empty FIFO never pops.
  - Count width is $clog2(DEPTH+1); read/write pointers wrap modulo DEPTH.
- **Reset values**
  - o_x_ready=0 while i_rst is high, then 1 from the first cycle after deassertion.
  - o_a_valid=0, o_b_valid=0, o_a_data=0, o_b_data=0.
  - Hold register empty; FIFO counts 0; round-robin pointer set to A.
- **Reset mid-operation:** all in-flight words, in the hold register and both FIFOs, are discarded. No partial or duplicate output is seen after release.

## Timing
- Minimum latency is 2 cycles: a word accepted at edge N is presented on A/B from edge N+1 onward (hold→FIFO at N+1) and is transferable at edge N+2.
- Throughput is 1 word/cycle sustained, to one output or alternating, while the destination sink keeps its ready high.
- Blocking:
  - A word destined for a full FIFO blocks the hold register.
  - This stalls X, including words bound for the other output (head-of-line blocking; accepted behaviour).
- Output order per destination equals input order; there is no ordering between A and B.

## Configuration
- DISTRIBUTOR_RR_EN defined:
  - Destination alternates A, B, A, B… per accepted X word, starting with A after reset.
  - ROUTE_BIT and the data content are ignored.
  - The pointer advances only on an X transfer.
- Not defined: the destination is i_x_data[ROUTE_BIT] and no pointer register exists.

## Structure
- stream_pkg (shared with the arbiter):
  - STREAM_DATA_W = 32
  - typedef logic [STREAM_DATA_W-1:0] stream_data_t
  - typedef enum logic {DEST_A=0, DEST_B=1} stream_dest_t
- Sub-module dist_fifo:
  - Parameterised synchronous FIFO (DEPTH, stream_data_t) with push, pop, full, empty and head data.
  - Same async active-high reset; instantiated twice.

## Test plan
- **Routed split:** X sends 0x0000_0001, 0x8000_0002, 0x0000_0003 with both readies high → A receives 1 then 3, B receives 0x8000_0002; first A valid 2 cycles after the first X transfer.
- **Backpressure isolation:** i_a_ready=0, then send three A-bound words (A FIFO fills with the first two) followed by one B-bound word → FIFO A holds 2, the third A-bound word sits in the hold register and o_x_ready drops. The B-bound word is blocked at X until i_a_ready rises. Afterwards all words are delivered in order.
- **Full with simultaneous pop:** A FIFO full, hold register loaded for A, and i_a_ready pulses for 1 cycle → one pop, and the push occurs the following cycle, not the same cycle.
- **Streaming:** 64 back-to-back words with alternating route bit and both readies high → o_x_ready stays 1 throughout; 32 words on each output in order.
- **Reset mid-flight:** 2 words in each FIFO plus the hold register loaded, then assert i_rst asynchronously between edges → valids drop immediately and o_x_ready=0. After release, o_x_ready=1 and no stale words emerge.
- **With DISTRIBUTOR_RR_EN:** 5 words all with bit31=1 → A,B,A,B,A by arrival; a stall on X between words does not advance the pointer.
